uart_tx_arbiter: RTL

Round-robin arbiter that shares the single `uart_tx` transmitter among `NUM_REQ` byte producers, such as the RX-FIFO echo path, the counter value reporter and status messages. It sits between the producers and the `uart_tx` `start_trigger`/`tx_data`/`tx_busy` interface. It issues one byte at a time and tracks `tx_busy` until each frame completes. Optionally it locks the grant for a multi-byte packet so that messages are not interleaved.

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among NUM_REQ byte producers
// Packet grant lock is compiled in with UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BUSY_GUARD = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       locked,
    output logic                       tx_err
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state, state_d;
    logic [IDW-1:0]     ptr, ptr_d, grant_d, winner;
    logic [3:0]         guard, guard_d;
    logic               start_d, active_d, err_d, lock_d, found;
    logic [7:0]         data_d;
    logic [NUM_REQ-1:0] ack_d, cand;
    logic [7:0]         req_byte [NUM_REQ];
    int                 idx;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        if (int'(i) == NUM_REQ - 1) return '0;
        return i + IDW'(1);
    endfunction

`ifndef UART_TX_ARB_LOCK_EN
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) req_byte[i] = req_data[8*i +: 8];
    end

    // Walk downward so the last hit is the first set index at or above ptr.
    always_comb begin
        cand = req_valid;
        if (locked) cand = req_valid & (NUM_REQ'(1) << grant_id);
        found  = 1'b0;
        winner = ptr;
        idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (cand[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        guard_d  = guard;
        start_d  = 1'b0;
        ack_d    = '0;
        data_d   = tx_data;
        grant_d  = grant_id;
        active_d = active;
        err_d    = 1'b0;
        lock_d   = locked;
        case (state)
            IDLE: begin
                if (found && !tx_busy) begin
                    start_d  = 1'b1;
                    data_d   = req_byte[winner];
                    ack_d    = NUM_REQ'(1) << winner;
                    grant_d  = winner;
                    active_d = 1'b1;
                    guard_d  = '0;
                    state_d  = WAIT_BUSY;
`ifdef UART_TX_ARB_LOCK_EN
                    if (req_last[winner]) begin
                        lock_d = 1'b0;
                        ptr_d  = next_idx(winner);
                    end else begin
                        lock_d = 1'b1;
                    end
`else
                    ptr_d = next_idx(winner);
`endif
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (guard + 4'd1 == 4'(BUSY_GUARD)) begin
                    // Transmitter never answered: drop the frame and release any packet lock.
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    lock_d   = 1'b0;
                    ptr_d    = next_idx(grant_id);
                    state_d  = IDLE;
                end else begin
                    guard_d = guard + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            guard    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            req_ack  <= '0;
            grant_id <= '0;
            active   <= 1'b0;
            locked   <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            guard    <= guard_d;
            tx_start <= start_d;
            tx_data  <= data_d;
            req_ack  <= ack_d;
            grant_id <= grant_d;
            active   <= active_d;
            locked   <= lock_d;
            tx_err   <= err_d;
        end
    end
endmodule
